bound_flasher_ctrl: RTL and testbench
=====================================

Name: bound_flasher_ctrl

Overview:
Parametrised bound-flasher controller for the next generation of the design. It combines the main state register, next-state logic, LED level counter and step prescaler in one block. It drives an N_LED thermometer-coded lamp bar through a six-phase up/down sequence with configurable bounds. A `flick` input starts the sequence and triggers kickback at defined points.

Parameters:
- N_LED, 16, number of lamps; top bound of phase UP3. Must be >= 3.
- B1, 6, first bound in lit lamps. Must satisfy 0 < B1 < B2.
- B2, 11, second bound in lit lamps. Must satisfy B2 < N_LED.
- STEP_DIV, 1, clock cycles per lamp step. Must be >= 1.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flick  in  1  start/kickback request, sampled synchronously on clk.
- led  out  N_LED  lamp bar; led[i] = 1 iff level > i.
- main_state  out  3  current phase encoding.
- busy  out  1  high whenever main_state != INIT.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: main_state = INIT (0), level = 0, prescaler = 0, led = 0, busy = 0. Reset asserted mid-sequence returns to these values immediately, with no completion of the current step.
- Internal registers:
  - level, width $clog2(N_LED+1), range 0..N_LED.
  - div_cnt, width $clog2(STEP_DIV) (minimum 1).
- State encoding: INIT=0, UP1=1, DN1=2, UP2=3, DN2=4, UP3=5, DN3=6. Value 7 is illegal and recovers to INIT with level = 0 on the next edge.
- Prescaler:
  - tick = (div_cnt == STEP_DIV-1) while in a non-INIT state.
  - div_cnt increments each cycle in non-INIT states and wraps to 0 on tick.
  - div_cnt is held at 0 in INIT.
  - With STEP_DIV=1, tick is high every non-INIT cycle.
- INIT: if flick = 1, next state is UP1 and level stays 0. Not tick-gated. With flick = 0, stay in INIT.
- Level changes happen only on tick cycles:
  - UP states: level <= level+1.
  - DN states: level <= level-1.
- Phase transitions, evaluated on tick using level before update:
  - UP1: when level+1 == B1, go to DN1.
  - DN1: when level-1 == 0, go to UP2.
  - UP2: when level+1 == B2, go to DN2.
  - DN2: when level-1 == B1, go to UP3.
  - UP3: when level+1 == N_LED, go to DN3.
  - DN3: when level-1 == 0, go to INIT.
- Transition and level update occur on the same edge. Level never leaves 0..N_LED.
- Kickback, evaluated on tick cycles only, takes priority over the normal UP action:
  - In UP2 with level == B1 and flick = 1: next state DN1, level <= level-1.
  - In UP3 with level == B2 and flick = 1: next state DN2, level <= level-1.
  - Repeated kickbacks are allowed indefinitely.
- Flick is ignored in all other states and cycles, including non-tick cycles at a kickback level.
- Outputs are registered-derived (pure decode of main_state and level); no combinational path from flick to outputs.
- Full uninterrupted sequence at STEP_DIV=1 with defaults: 1 + 6 + 6 + 11 + 5 + 10 + 16 = 55 edges from flick sample back to INIT.

Test Plan:
- Reset/idle: assert rst_n=0 mid-UP2 at level 8 → led = 0 and main_state = 0 without a clk edge. Release with flick = 0 for 20 cycles → stays INIT, busy = 0.
- Full sequence (defaults): one-cycle flick → UP1 at edge 1; led = 16'h003F with DN1 at edge 7; level 0 with UP2 at edge 13; led = 16'h07FF with DN2 at edge 24; level 6 with UP3 at edge 29; led = 16'hFFFF with DN3 at edge 39; INIT at edge 55.
- Kickback UP2: hold flick = 1 continuously through the pass of level 6 in UP2 → DN1 entered each time level reaches 6. Level oscillates 6→0→6, never exceeds 6.
- Kickback UP3: pulse flick in the cycle level == 11 in UP3 → main_state = 4 and level = 10 next edge. Then DN2 to 6, UP3 resumes.
- Ignored flick: pulse flick at level 6 during UP1, DN1 and DN3, and at level 7 in UP2 → trace identical to the no-flick run.
- Prescaler: STEP_DIV=4, N_LED=8, B1=2, B2=5; flick once → each level change exactly 4 cycles apart. A kickback pulse on a non-tick cycle at level 2 in UP2 is ignored; the same pulse on the tick cycle is honoured.

Source files
------------

// File: rtl/bound_flasher_ctrl.sv
// Bound-flasher controller: drives a thermometer-coded lamp bar through a
// six-phase up/down sequence with configurable bounds, a step prescaler and flick kickback.
module bound_flasher_ctrl #(
  parameter int N_LED    = 16,
  parameter int B1       = 6,
  parameter int B2       = 11,
  parameter int STEP_DIV = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flick,
  output logic [N_LED-1:0] led,
  output logic [2:0]       main_state,
  output logic             busy
);

  localparam int LW = $clog2(N_LED + 1);
  localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [LW-1:0] L_ZERO = '0;
  localparam logic [LW-1:0] L_ONE  = LW'(1);
  localparam logic [LW-1:0] L_B1   = LW'(B1);
  localparam logic [LW-1:0] L_B2   = LW'(B2);
  localparam logic [LW-1:0] L_TOP  = LW'(N_LED);
  localparam logic [DW-1:0] D_ONE  = DW'(1);
  localparam logic [DW-1:0] D_LAST = DW'(STEP_DIV - 1);

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_UP1  = 3'd1,
    S_DN1  = 3'd2,
    S_UP2  = 3'd3,
    S_DN2  = 3'd4,
    S_UP3  = 3'd5,
    S_DN3  = 3'd6
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [LW-1:0] r_level;
  logic [LW-1:0] w_level_nxt;
  logic [LW-1:0] w_level_inc;
  logic [LW-1:0] w_level_dec;
  logic [DW-1:0] r_div;
  logic [DW-1:0] w_div_nxt;
  logic          w_tick;

  assign w_level_inc = r_level + L_ONE;
  assign w_level_dec = r_level - L_ONE;
  assign w_tick      = (r_state != S_INIT) && (r_div == D_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_INIT;
      r_level <= '0;
      r_div   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_level <= w_level_nxt;
      r_div   <= w_div_nxt;
    end
  end

  // Phase exits compare the post-step level, so transition and step share one edge.
  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    w_div_nxt   = w_tick ? '0 : (r_div + D_ONE);
    case (r_state)
      S_INIT: begin
        w_div_nxt = '0;
        if (flick) w_state_nxt = S_UP1;
      end
      S_UP1: begin
        if (w_tick) begin
          w_level_nxt = w_level_inc;
          if (w_level_inc == L_B1) w_state_nxt = S_DN1;
        end
      end
      S_DN1: begin
        if (w_tick) begin
          w_level_nxt = w_level_dec;
          if (w_level_dec == L_ZERO) w_state_nxt = S_UP2;
        end
      end
      S_UP2: begin
        if (w_tick) begin
          if (flick && (r_level == L_B1)) begin
            w_level_nxt = w_level_dec;
            w_state_nxt = S_DN1;
          end else begin
            w_level_nxt = w_level_inc;
            if (w_level_inc == L_B2) w_state_nxt = S_DN2;
          end
        end
      end
      S_DN2: begin
        if (w_tick) begin
          w_level_nxt = w_level_dec;
          if (w_level_dec == L_B1) w_state_nxt = S_UP3;
        end
      end
      S_UP3: begin
        if (w_tick) begin
          if (flick && (r_level == L_B2)) begin
            w_level_nxt = w_level_dec;
            w_state_nxt = S_DN2;
          end else begin
            w_level_nxt = w_level_inc;
            if (w_level_inc == L_TOP) w_state_nxt = S_DN3;
          end
        end
      end
      S_DN3: begin
        if (w_tick) begin
          w_level_nxt = w_level_dec;
          if (w_level_dec == L_ZERO) w_state_nxt = S_INIT;
        end
      end
      default: begin
        // Unused encoding 7: drop straight back to idle.
        w_state_nxt = S_INIT;
        w_level_nxt = '0;
        w_div_nxt   = '0;
      end
    endcase
  end

  for (genvar g = 0; g < N_LED; g++) begin : g_led
    assign led[g] = (r_level > LW'(g));
  end

  assign main_state = r_state;
  assign busy       = (r_state != S_INIT);

endmodule

// File: tb/tb_bound_flasher_ctrl.sv
// Scoreboard bench for bound_flasher_ctrl: a default instance and a prescaled
// instance (N_LED=8, B1=2, B2=5, STEP_DIV=4) checked against a cycle model.
module tb_bound_flasher_ctrl;

  localparam int N0 = 16, B10 = 6, B20 = 11, SD0 = 1;
  localparam int N1 = 8,  B11 = 2, B21 = 5,  SD1 = 4;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          flick0 = 1'b0;
  logic          flick1 = 1'b0;
  logic [N0-1:0] led0;
  logic [2:0]    st0;
  logic          busy0;
  logic [N1-1:0] led1;
  logic [2:0]    st1;
  logic          busy1;

  int n_vec = 0;
  int n_mis = 0;

  typedef struct {
    int d;
    int st;
    int lv;
  } exp_t;

  exp_t sb[$];
  int   m_st[2];
  int   m_lv[2];
  int   m_dv[2];

  int          cnt_e;
  int          kicks;
  int          last_e;
  int          prev_lv;
  int          cur_lv;
  logic [31:0] max_led;
  logic [2:0]  prev_st;
  bit          f;

  always #5 clk = ~clk;

  bound_flasher_ctrl #(.N_LED(N0), .B1(B10), .B2(B20), .STEP_DIV(SD0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flick(flick0),
    .led(led0), .main_state(st0), .busy(busy0)
  );

  bound_flasher_ctrl #(.N_LED(N1), .B1(B11), .B2(B21), .STEP_DIV(SD1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flick(flick1),
    .led(led1), .main_state(st1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] therm(input int lv);
    return (32'h1 << lv) - 32'h1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0;
      m_lv[i] = 0;
      m_dv[i] = 0;
    end
  endtask

  task automatic model_step(input int d, input bit fl);
    int n, b1, b2, sd, st, lv, dv;
    bit tick;
    n  = (d != 0) ? N1 : N0;
    b1 = (d != 0) ? B11 : B10;
    b2 = (d != 0) ? B21 : B20;
    sd = (d != 0) ? SD1 : SD0;
    st = m_st[d];
    lv = m_lv[d];
    dv = m_dv[d];
    if (st == 0) begin
      dv = 0;
      if (fl) st = 1;
    end else begin
      tick = (dv == sd - 1);
      dv   = tick ? 0 : dv + 1;
      if (tick) begin
        case (st)
          1: begin lv++; if (lv == b1) st = 2; end
          2: begin lv--; if (lv == 0) st = 3; end
          3: if (fl && lv == b1) begin lv--; st = 2; end
             else begin lv++; if (lv == b2) st = 4; end
          4: begin lv--; if (lv == b1) st = 5; end
          5: if (fl && lv == b2) begin lv--; st = 4; end
             else begin lv++; if (lv == n) st = 6; end
          6: begin lv--; if (lv == 0) st = 0; end
          default: begin st = 0; lv = 0; end
        endcase
      end
    end
    m_st[d] = st;
    m_lv[d] = lv;
    m_dv[d] = dv;
  endtask

  // One clock of stimulus: predict, queue, wait for the edge and the compare.
  task automatic step(input int d, input bit fl);
    exp_t e;
    if (d == 0) flick0 = fl;
    else        flick1 = fl;
    model_step(d, fl);
    e.d  = d;
    e.st = m_st[d];
    e.lv = m_lv[d];
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    #1;
    flick0 = 1'b0;
    flick1 = 1'b0;
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.d == 0) begin
        chk("state0", 32'(st0), 32'(e.st));
        chk("led0", 32'(led0), therm(e.lv));
        chk("busy0", 32'(busy0), 32'(e.st != 0));
      end else begin
        chk("state1", 32'(st1), 32'(e.st));
        chk("led1", 32'(led1), therm(e.lv));
        chk("busy1", 32'(busy1), 32'(e.st != 0));
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_led0", 32'(led0), 32'h0);
    chk("rst_st0", 32'(st0), 32'h0);
    chk("rst_busy0", 32'(busy0), 32'h0);
    chk("rst_st1", 32'(st1), 32'h0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Full uninterrupted sequence on the default instance.
    step(0, 1'b1);
    chk("fs_e1_st", 32'(st0), 32'd1);
    for (int e = 2; e <= 55; e++) begin
      step(0, 1'b0);
      case (e)
        7:  begin chk("fs_e7_led", 32'(led0), 32'h003F); chk("fs_e7_st", 32'(st0), 32'd2); end
        13: begin chk("fs_e13_led", 32'(led0), 32'h0000); chk("fs_e13_st", 32'(st0), 32'd3); end
        24: begin chk("fs_e24_led", 32'(led0), 32'h07FF); chk("fs_e24_st", 32'(st0), 32'd4); end
        29: begin chk("fs_e29_led", 32'(led0), 32'h003F); chk("fs_e29_st", 32'(st0), 32'd5); end
        39: begin chk("fs_e39_led", 32'(led0), 32'hFFFF); chk("fs_e39_st", 32'(st0), 32'd6); end
        55: begin chk("fs_e55_st", 32'(st0), 32'd0); chk("fs_e55_busy", 32'(busy0), 32'd0); end
        default: ;
      endcase
    end
    repeat (3) step(0, 1'b0);

    // Flick pulses where they must be ignored; the run length must not change.
    step(0, 1'b1);
    cnt_e = 1;
    while (busy0 && cnt_e < 100) begin
      f = (m_st[0] == 1 && m_lv[0] == 5) || (m_st[0] == 2 && m_lv[0] == 6) ||
          (m_st[0] == 3 && m_lv[0] == 7) || (m_st[0] == 6 && m_lv[0] == 6);
      step(0, f);
      cnt_e++;
    end
    chk("ign_len", 32'(cnt_e), 32'd55);
    repeat (2) step(0, 1'b0);

    // Kickback out of UP3 at level 11.
    step(0, 1'b1);
    cnt_e = 0;
    while (!(m_st[0] == 5 && m_lv[0] == 11) && cnt_e < 60) begin
      step(0, 1'b0);
      cnt_e++;
    end
    chk("kb3_reach", 32'(cnt_e < 60), 32'd1);
    step(0, 1'b1);
    chk("kb3_st", 32'(st0), 32'd4);
    chk("kb3_led", 32'(led0), 32'h03FF);
    repeat (4) step(0, 1'b0);
    chk("kb3_back_st", 32'(st0), 32'd5);
    chk("kb3_back_led", 32'(led0), 32'h003F);
    cnt_e = 0;
    while (busy0 && cnt_e < 100) begin
      step(0, 1'b0);
      cnt_e++;
    end
    chk("kb3_done", 32'(busy0), 32'd0);

    // Flick held high: UP2 keeps kicking back to DN1 at level 6.
    max_led = '0;
    kicks   = 0;
    prev_st = st0;
    for (int e = 1; e <= 80; e++) begin
      step(0, 1'b1);
      if (32'(led0) > max_led) max_led = 32'(led0);
      if (prev_st == 3'd3 && st0 == 3'd2) kicks++;
      prev_st = st0;
    end
    chk("kb2_max_led", max_led, 32'h003F);
    chk("kb2_kicks", 32'(kicks), 32'd6);
    rst_n = 1'b0;
    #1;
    chk("kb2_rst_st", 32'(st0), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Asynchronous reset in UP2 at level 8, then idle.
    step(0, 1'b1);
    repeat (20) step(0, 1'b0);
    chk("rs_pre_led", 32'(led0), 32'h00FF);
    chk("rs_pre_st", 32'(st0), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("rs_led", 32'(led0), 32'h0);
    chk("rs_st", 32'(st0), 32'd0);
    chk("rs_busy", 32'(busy0), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) step(0, 1'b0);
    chk("idle_st", 32'(st0), 32'd0);
    chk("idle_busy", 32'(busy0), 32'd0);

    // Prescaled instance: 4-cycle steps, kickback only on the tick cycle.
    step(1, 1'b1);
    last_e  = 1;
    prev_lv = 0;
    for (int e = 2; e <= 400; e++) begin
      if (!busy1) break;
      step(1, (e == 26) || (e == 29));
      cur_lv = $countones(led1);
      if (cur_lv != prev_lv) begin
        chk("p4_gap", 32'(e - last_e), 32'd4);
        last_e  = e;
        prev_lv = cur_lv;
      end
      if (e == 26) begin
        chk("p4_ntick_st", 32'(st1), 32'd3);
        chk("p4_ntick_led", 32'(led1), 32'h03);
      end
      if (e == 29) begin
        chk("p4_tick_st", 32'(st1), 32'd2);
        chk("p4_tick_led", 32'(led1), 32'h01);
      end
    end
    chk("p4_done", 32'(busy1), 32'd0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
